lock_display_ctrl: RTL and testbench

- Upstream driver for the 5-bit glyph decoder (binary_to_segment) on the digital lock's 4-digit multiplexed 7-segment display.
- Holds the keypad digits entered so far and shows transient OPEN / FAIL messages after a lock comparison.
- Time-multiplexes the four digit positions: each slot emits one active-low anode select plus the 5-bit glyph code for the decoder.

---
 rtl/lock_display_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_lock_display_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_display_ctrl.sv
// Digital lock display controller: keypad entry buffer, OPEN/FAIL message FSM
// and the 4-digit multiplexed glyph scan that feeds the 7-segment decoder.

module lock_display_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int MSG_TICKS   = 2000,
   parameter int BLINK_TICKS = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        digit_valid,
   input  logic [3:0]  digit_in,
   input  logic        clear,
   input  logic        result_valid,
   input  logic        result_ok,
   output logic [4:0]  code_out,
   output logic [3:0]  anode,
   output logic [15:0] entry_code,
   output logic        entry_full,
   output logic        busy
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int MW = $clog2(MSG_TICKS + 1);
   localparam int BW = $clog2(BLINK_TICKS + 1);

   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
   localparam logic [MW-1:0] MSG_LAST   = MW'(MSG_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   localparam logic [4:0] G_O     = 5'd0;
   localparam logic [4:0] G_I     = 5'd1;
   localparam logic [4:0] G_A     = 5'd10;
   localparam logic [4:0] G_E     = 5'd14;
   localparam logic [4:0] G_F     = 5'd15;
   localparam logic [4:0] G_DASH  = 5'd16;
   localparam logic [4:0] G_L     = 5'd17;
   localparam logic [4:0] G_P     = 5'd19;
   localparam logic [4:0] G_N     = 5'd20;
   localparam logic [4:0] G_BLANK = 5'd21;

   typedef enum logic [1:0] {
      ST_ENTRY = 2'd0,
      ST_OPEN  = 2'd1,
      ST_FAIL  = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_next_s;
   logic            busy_r;
   logic            busy_next_s;

   logic [RW-1:0]   ref_cnt_r;
   logic            tick_s;
   logic [1:0]      scan_idx_r;
   logic [1:0]      scan_next_s;
   logic [3:0]      anode_r;
   logic [3:0]      anode_next_s;
   logic [4:0]      code_r;
   logic [4:0]      code_next_s;

   logic [MW-1:0]   msg_cnt_r;
   logic [BW-1:0]   blink_cnt_r;
   logic            blink_on_r;
   logic            expire_s;

   logic [15:0]     entry_r;
   logic [2:0]      count_r;
   logic            full_r;
   logic            accept_s;

   // Glyph for one digit slot, given the display mode and the entry buffer.
   function automatic logic [4:0] slot_glyph(
      input state_t      st,
      input logic [15:0] code,
      input logic [2:0]  cnt,
      input logic        blink_on,
      input logic [1:0]  idx
   );
      logic [4:0] g;
      g = G_DASH;
      case (st)
         ST_ENTRY: begin
            if ({1'b0, idx} < cnt) begin
               g = {1'b0, code[{idx, 2'b00} +: 4]};
            end else begin
               g = G_DASH;
            end
         end
         ST_OPEN: begin
            case (idx)
               2'd3:    g = G_O;
               2'd2:    g = G_P;
               2'd1:    g = G_E;
               2'd0:    g = G_N;
               default: g = G_DASH;
            endcase
         end
         ST_FAIL: begin
            if (!blink_on) begin
               g = G_BLANK;
            end else begin
               case (idx)
                  2'd3:    g = G_F;
                  2'd2:    g = G_A;
                  2'd1:    g = G_I;
                  2'd0:    g = G_L;
                  default: g = G_DASH;
               endcase
            end
         end
         default: g = G_DASH;
      endcase
      return g;
   endfunction

   assign tick_s   = (ref_cnt_r == REF_LAST);
   assign expire_s = tick_s && (msg_cnt_r == MSG_LAST) && (state_r != ST_ENTRY);

   // State register; busy is kept in step with the state it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_ENTRY;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= busy_next_s;
      end
   end

   // Next-state logic; clear outranks a result, which outranks message expiry.
   always_comb begin
      state_next_s = state_r;
      if (clear) begin
         state_next_s = ST_ENTRY;
      end else begin
         case (state_r)
            ST_ENTRY: begin
               if (result_valid) begin
                  state_next_s = result_ok ? ST_OPEN : ST_FAIL;
               end else begin
                  state_next_s = ST_ENTRY;
               end
            end
            ST_OPEN, ST_FAIL: begin
               if (expire_s) begin
                  state_next_s = ST_ENTRY;
               end else begin
                  state_next_s = state_r;
               end
            end
            default: state_next_s = ST_ENTRY;
         endcase
      end
   end

   // Output logic: next values of the registered display outputs and strobes.
   always_comb begin
      scan_next_s  = scan_idx_r + 2'd1;
      anode_next_s = ~(4'b0001 << scan_next_s);
      code_next_s  = slot_glyph(state_r, entry_r, count_r, blink_on_r, scan_next_s);
      busy_next_s  = (state_next_s != ST_ENTRY);
      accept_s     = (state_r == ST_ENTRY) && !clear && !result_valid && digit_valid &&
                     (digit_in <= 4'd9) && (count_r < 3'd4);
   end

   // Slot timer and scan; anode and glyph are only loaded together on a tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt_r  <= {RW{1'b0}};
         scan_idx_r <= 2'd0;
         anode_r    <= 4'b1110;
         code_r     <= G_DASH;
      end else if (tick_s) begin
         ref_cnt_r  <= {RW{1'b0}};
         scan_idx_r <= scan_next_s;
         anode_r    <= anode_next_s;
         code_r     <= code_next_s;
      end else begin
         ref_cnt_r  <= ref_cnt_r + RW'(1'b1);
      end
   end

   // Message lifetime and blink phase; held at their start values outside a message.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msg_cnt_r   <= {MW{1'b0}};
         blink_cnt_r <= {BW{1'b0}};
         blink_on_r  <= 1'b1;
      end else if (clear || (state_r == ST_ENTRY)) begin
         msg_cnt_r   <= {MW{1'b0}};
         blink_cnt_r <= {BW{1'b0}};
         blink_on_r  <= 1'b1;
      end else if (tick_s) begin
         if (msg_cnt_r == MSG_LAST) begin
            msg_cnt_r <= {MW{1'b0}};
         end else begin
            msg_cnt_r <= msg_cnt_r + MW'(1'b1);
         end
         if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_on_r  <= ~blink_on_r;
         end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1'b1);
         end
      end
   end

   // Entry buffer: newest digit shifts in at the low nibble, capped at four.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_r <= 16'h0000;
         count_r <= 3'd0;
         full_r  <= 1'b0;
      end else if (clear || expire_s) begin
         entry_r <= 16'h0000;
         count_r <= 3'd0;
         full_r  <= 1'b0;
      end else if (accept_s) begin
         entry_r <= {entry_r[11:0], digit_in};
         count_r <= count_r + 3'd1;
         full_r  <= (count_r == 3'd3);
      end
   end

   assign code_out   = code_r;
   assign anode      = anode_r;
   assign entry_code = entry_r;
   assign entry_full = full_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_lock_display_ctrl.sv
// Directed scoreboard bench for lock_display_ctrl: expected slot glyphs are
// queued with each stimulus step and compared as each slot update appears.

module tb_lock_display_ctrl;

   localparam int RD = 4;
   localparam int MT = 8;
   localparam int BT = 2;

   logic        clk;
   logic        rst;
   logic        digit_valid;
   logic [3:0]  digit_in;
   logic        clear;
   logic        result_valid;
   logic        result_ok;
   logic [4:0]  code_out;
   logic [3:0]  anode;
   logic [15:0] entry_code;
   logic        entry_full;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_cyc = 0;
   logic [1:0] tb_idx;

   typedef struct {
      string           tag;
      logic [3:0][4:0] c;
   } slot_exp_t;

   slot_exp_t sb[$];

   lock_display_ctrl #(
      .REFRESH_DIV (RD),
      .MSG_TICKS   (MT),
      .BLINK_TICKS (BT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .digit_valid  (digit_valid),
      .digit_in     (digit_in),
      .clear        (clear),
      .result_valid (result_valid),
      .result_ok    (result_ok),
      .code_out     (code_out),
      .anode        (anode),
      .entry_code   (entry_code),
      .entry_full   (entry_full),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_pat(input string tag, input logic [4:0] c3, input logic [4:0] c2,
                           input logic [4:0] c1, input logic [4:0] c0, input int n);
      slot_exp_t e;
      e.tag = tag;
      e.c   = {c3, c2, c1, c0};
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   // Wait for n slot updates; check anode, slot period and the queued glyph.
   task automatic advance(input int n);
      for (int k = 0; k < n; k++) begin
         logic [3:0] prev;
         logic [3:0] exp_an;
         bit         seen;
         slot_exp_t  e;
         prev = anode;
         seen = 1'b0;
         for (int w = 0; w < 3 * RD && !seen; w++) begin
            @(posedge clk);
            #1;
            if (anode !== prev) seen = 1'b1;
         end
         chk("slot_timeout", {31'd0, seen}, 32'd1);
         if (seen) begin
            tb_idx = tb_idx + 2'd1;
            exp_an = ~(4'b0001 << tb_idx);
            chk("anode", {28'd0, anode}, {28'd0, exp_an});
            chk("slot_period", cyc - last_cyc, RD);
            last_cyc = cyc;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk({e.tag, "_code"}, {27'd0, code_out}, {27'd0, e.c[tb_idx]});
            end
         end
      end
   endtask

   task automatic key(input logic [3:0] d);
      digit_in    = d;
      digit_valid = 1'b1;
      @(posedge clk);
      #1 digit_valid = 1'b0;
   endtask

   task automatic result(input logic ok);
      result_ok    = ok;
      result_valid = 1'b1;
      @(posedge clk);
      #1 result_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      digit_valid  = 1'b0;
      digit_in     = 4'd0;
      clear        = 1'b0;
      result_valid = 1'b0;
      result_ok    = 1'b0;
      tb_idx       = 2'd0;
      #12;
      chk("rst_anode", {28'd0, anode}, 32'he);
      chk("rst_code",  {27'd0, code_out}, 32'd16);
      chk("rst_entry", {16'd0, entry_code}, 32'd0);
      chk("rst_full",  {31'd0, entry_full}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      last_cyc = cyc;

      // idle scan: dashes everywhere
      push_pat("idle", 5'd16, 5'd16, 5'd16, 5'd16, 4);
      advance(4);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // digit entry, non-decimal key ignored
      key(4'd1); key(4'd2); key(4'hA);
      chk("e12_entry", {16'd0, entry_code}, 32'h0012);
      chk("e12_full",  {31'd0, entry_full}, 32'd0);
      push_pat("e12", 5'd16, 5'd16, 5'd1, 5'd2, 4);
      advance(4);
      key(4'd3); key(4'd4); key(4'd5);
      chk("e1234_entry", {16'd0, entry_code}, 32'h1234);
      chk("e1234_full",  {31'd0, entry_full}, 32'd1);
      push_pat("e1234", 5'd1, 5'd2, 5'd3, 5'd4, 4);
      advance(4);

      // OPEN message, strobes ignored while it shows
      result(1'b1);
      chk("open_busy", {31'd0, busy}, 32'd1);
      push_pat("open", 5'd0, 5'd19, 5'd14, 5'd20, 8);
      advance(1);
      key(4'd9);
      result(1'b0);
      chk("open_ign_entry", {16'd0, entry_code}, 32'h1234);
      chk("open_ign_busy",  {31'd0, busy}, 32'd1);
      advance(7);
      chk("open_end_busy",  {31'd0, busy}, 32'd0);
      chk("open_end_entry", {16'd0, entry_code}, 32'd0);
      chk("open_end_full",  {31'd0, entry_full}, 32'd0);
      push_pat("post_open", 5'd16, 5'd16, 5'd16, 5'd16, 4);
      advance(4);

      // FAIL message with blink
      result(1'b0);
      chk("fail_busy", {31'd0, busy}, 32'd1);
      push_pat("fail_on1",  5'd15, 5'd10, 5'd1,  5'd17, 2);
      push_pat("fail_off1", 5'd21, 5'd21, 5'd21, 5'd21, 2);
      push_pat("fail_on2",  5'd15, 5'd10, 5'd1,  5'd17, 2);
      push_pat("fail_off2", 5'd21, 5'd21, 5'd21, 5'd21, 2);
      advance(8);
      chk("fail_end_busy", {31'd0, busy}, 32'd0);
      push_pat("post_fail", 5'd16, 5'd16, 5'd16, 5'd16, 2);
      advance(2);

      // clear beats result and digit in the same cycle
      key(4'd5); key(4'd6);
      chk("pre_clr_entry", {16'd0, entry_code}, 32'h0056);
      clear        = 1'b1;
      digit_in     = 4'd7;
      digit_valid  = 1'b1;
      result_ok    = 1'b1;
      result_valid = 1'b1;
      @(posedge clk);
      #1;
      clear        = 1'b0;
      digit_valid  = 1'b0;
      result_valid = 1'b0;
      chk("clr_entry", {16'd0, entry_code}, 32'd0);
      chk("clr_full",  {31'd0, entry_full}, 32'd0);
      chk("clr_busy",  {31'd0, busy}, 32'd0);
      push_pat("post_clr", 5'd16, 5'd16, 5'd16, 5'd16, 4);
      advance(4);

      // clear aborts a message
      result(1'b1);
      chk("abort_busy_on", {31'd0, busy}, 32'd1);
      pulse_clear();
      chk("abort_busy_off", {31'd0, busy}, 32'd0);
      push_pat("post_abort", 5'd16, 5'd16, 5'd16, 5'd16, 2);
      advance(2);

      // asynchronous reset in the middle of FAIL
      key(4'd8); key(4'd9);
      result(1'b0);
      push_pat("fail_pre_rst", 5'd15, 5'd10, 5'd1, 5'd17, 2);
      advance(2);
      chk("fail_pre_rst_entry", {16'd0, entry_code}, 32'h0089);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_anode", {28'd0, anode}, 32'he);
      chk("arst_code",  {27'd0, code_out}, 32'd16);
      chk("arst_busy",  {31'd0, busy}, 32'd0);
      chk("arst_entry", {16'd0, entry_code}, 32'd0);
      chk("arst_full",  {31'd0, entry_full}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      tb_idx   = 2'd0;
      last_cyc = cyc;
      chk("rel_anode", {28'd0, anode}, 32'he);
      push_pat("post_rst", 5'd16, 5'd16, 5'd16, 5'd16, 3);
      advance(3);

      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
